// File: rtl/auth_sequencer_pkg.sv
// auth_sequencer_pkg: shared codes, states and timeout
// constants for the authentication sequencer.
package auth_sequencer_pkg;

  localparam int DEF_TMR_W       = 32;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int DEF_TIMEOUT     = 1000;
  localparam int HDR_VERSION     = 8'h11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_e;

  typedef enum logic [1:0] {
    PH_DIGESTS,
    PH_CERT,
    PH_CHAL
  } phase_e;

  localparam logic [1:0] RT_NONE        = 2'd0;
  localparam logic [1:0] RT_CHALLENGE   = 2'd1;
  localparam logic [1:0] RT_DIGESTS     = 2'd2;
  localparam logic [1:0] RT_CERTIFICATE = 2'd3;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_CERT    = 2'd2;
  localparam logic [1:0] FC_BUSY    = 2'd3;

  function automatic logic [1:0] phase_code(
    input phase_e p
  );
    logic [1:0] c;
    case (p)
      PH_DIGESTS: c = RT_DIGESTS;
      PH_CERT:    c = RT_CERTIFICATE;
      PH_CHAL:    c = RT_CHALLENGE;
      default:    c = RT_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/auth_sequencer_if.sv
// auth_sequencer_if: control, responder and initiator
// signals of the authentication sequencer.
interface auth_sequencer_if #(
  parameter int TMR_W = 32
);
  logic             start;
  logic             abort;
  logic [1:0]       slot_sel;
  logic             init_ack;
  logic             resp_valid;
  logic             cert_done;
  logic             cert_fail;
  logic             busy_err;
  logic [TMR_W-1:0] timeout_val;
  logic             init_req;
  logic [1:0]       req_type;
  logic [1:0]       slot;
  logic             ack_to_init;
  logic             busy;
  logic             auth_done;
  logic             auth_fail;
  logic [1:0]       fail_code;
  logic [1:0]       retry_cnt;

  modport slave (
    input  start, abort, slot_sel, init_ack,
    input  resp_valid, cert_done, cert_fail,
    input  busy_err, timeout_val,
    output init_req, req_type, slot, ack_to_init,
    output busy, auth_done, auth_fail,
    output fail_code, retry_cnt
  );

  modport master (
    output start, abort, slot_sel, init_ack,
    output resp_valid, cert_done, cert_fail,
    output busy_err, timeout_val,
    input  init_req, req_type, slot, ack_to_init,
    input  busy, auth_done, auth_fail,
    input  fail_code, retry_cnt
  );
endinterface

// File: rtl/auth_sequencer_timer.sv
// auth_timeout_timer: per-request timeout counter,
// loaded on initiator ack, saturating down-count.
module auth_timeout_timer #(
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);
  logic [TMR_W-1:0] count;

  // load wins over decrement; count holds at zero
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);
endmodule

// File: rtl/auth_sequencer.sv
// auth_sequencer: drives DIGESTS, CERTIFICATE, CHALLENGE
// requests through the initiator with per-phase retries.
module auth_sequencer
  import auth_sequencer_pkg::*;
#(
  parameter int MAX_RETRIES = DEF_MAX_RETRIES,
  parameter int TMR_W       = DEF_TMR_W
) (
  input  logic clk,
  input  logic reset,
  auth_sequencer_if.slave bus
);
  localparam logic [1:0] MAX_R = 2'(MAX_RETRIES);

  state_e     state;
  phase_e     phase;
  logic [1:0] retry_q;
  logic [1:0] slot_q;
  logic [1:0] req_type_q;
  logic [1:0] fail_code_q;
  logic       init_req_q;
  logic       ack_q;
  logic       busy_q;
  logic       done_q;
  logic       fail_q;
  logic       in_issue;
  logic       in_wait;
  logic       tmr_expired;
  logic       ev_cfail;
  logic       ev_succ;
  logic       ev_err;
  logic       retry_ok;
  logic [1:0] err_code;

  assign in_issue = (state == S_ISSUE);
  assign in_wait  = (state == S_WAIT);

  auth_timeout_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.abort),
    .load     (in_issue && bus.init_ack),
    .dec      (in_wait),
    .load_val (bus.timeout_val),
    .expired  (tmr_expired)
  );

  // classify responder events against the current phase
  always_comb begin
    ev_cfail = 1'b0;
    ev_succ  = 1'b0;
    if (in_wait) begin
      if (phase == PH_CERT) begin
        ev_cfail = bus.cert_fail;
        ev_succ  = bus.cert_done;
      end else begin
        ev_succ  = bus.resp_valid;
      end
    end
    ev_err = ((in_issue || in_wait) && bus.busy_err)
           || (in_wait && tmr_expired);
    err_code = bus.busy_err ? FC_BUSY : FC_TIMEOUT;
    retry_ok = (retry_q < MAX_R);
  end

  // sequencer FSM; every output is a register here
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= PH_DIGESTS;
      retry_q     <= '0;
      slot_q      <= '0;
      req_type_q  <= RT_NONE;
      fail_code_q <= FC_NONE;
      init_req_q  <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (bus.abort) begin
        state       <= S_IDLE;
        phase       <= PH_DIGESTS;
        retry_q     <= '0;
        req_type_q  <= RT_NONE;
        fail_code_q <= FC_NONE;
        init_req_q  <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (bus.start) begin
              state       <= S_ISSUE;
              slot_q      <= bus.slot_sel;
              phase       <= PH_DIGESTS;
              retry_q     <= '0;
              done_q      <= 1'b0;
              fail_q      <= 1'b0;
              fail_code_q <= FC_NONE;
              init_req_q  <= 1'b1;
              req_type_q  <= RT_DIGESTS;
              busy_q      <= 1'b1;
            end
          end
          S_ISSUE, S_WAIT: begin
            if (ev_cfail ||
                (ev_err && !ev_succ && !retry_ok)) begin
              state       <= S_FAIL;
              fail_q      <= 1'b1;
              fail_code_q <= ev_cfail ? FC_CERT : err_code;
              busy_q      <= 1'b0;
              init_req_q  <= 1'b0;
              req_type_q  <= RT_NONE;
            end else if (ev_succ) begin
              retry_q    <= '0;
              init_req_q <= 1'b0;
              req_type_q <= RT_NONE;
              if (phase == PH_CHAL) begin
                state  <= S_DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                state <= S_GAP;
                phase <= (phase == PH_DIGESTS)
                         ? PH_CERT : PH_CHAL;
              end
            end else if (ev_err) begin
              retry_q    <= retry_q + 1'b1;
              state      <= S_GAP;
              init_req_q <= 1'b0;
              req_type_q <= RT_NONE;
            end else if (in_issue && bus.init_ack) begin
              ack_q <= 1'b1;
              state <= S_WAIT;
            end
          end
          S_GAP: begin
            state      <= S_ISSUE;
            init_req_q <= 1'b1;
            req_type_q <= phase_code(phase);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.init_req    = init_req_q;
  assign bus.req_type    = req_type_q;
  assign bus.slot        = slot_q;
  assign bus.ack_to_init = ack_q;
  assign bus.busy        = busy_q;
  assign bus.auth_done   = done_q;
  assign bus.auth_fail   = fail_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.retry_cnt   = retry_q;
endmodule

// File: tb/tb_auth_sequencer.sv
// tb_auth_sequencer: randomized scoreboard bench with a
// phase-level reference model of the auth sequence.
module tb_auth_sequencer;
  import auth_sequencer_pkg::*;

  localparam int TW   = 32;
  localparam int MAXR = 3;

  typedef enum int {
    A_OK, A_TMO, A_BUSY, A_CFAIL,
    A_CBOTH, A_ABORT, A_RST
  } act_e;

  typedef struct {
    act_e act;
    int   ack_dly;
    int   dly;
    int   code;
  } att_t;

  typedef struct {
    bit fin;
    int rt;
    int rc;
    int sl;
    bit done;
    int fc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   fin_kind;
  int   fin_fc;
  exp_t sbq[$];
  att_t plan[$];
  att_t force_q[$];

  always #5 clk = ~clk;

  auth_sequencer_if #(.TMR_W(TW)) bus ();

  auth_sequencer #(
    .MAX_RETRIES (MAXR),
    .TMR_W       (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_issue(int rt, int rc, int sl);
    exp_t e;
    e.fin = 0; e.rt = rt; e.rc = rc;
    e.sl = sl; e.done = 0; e.fc = 0;
    return e;
  endfunction

  function automatic exp_t mk_fin(bit done, int fc, int sl);
    exp_t e;
    e.fin = 1; e.rt = 0; e.rc = 0;
    e.sl = sl; e.done = done; e.fc = fc;
    return e;
  endfunction

  task automatic fq(input act_e act, input int dly);
    att_t a;
    a.act = act; a.dly = dly;
    a.ack_dly = 0; a.code = 0;
    force_q.push_back(a);
  endtask

  task automatic next_att(input int code, input int T,
                          output att_t a);
    int r;
    if (force_q.size() > 0) begin
      a = force_q.pop_front();
    end else begin
      r = $urandom_range(0, 9);
      a.dly = -1;
      if (r < 6)       a.act = A_OK;
      else if (r < 8)  a.act = A_TMO;
      else if (r == 8) a.act = A_BUSY;
      else if (code == 3)
        a.act = ($urandom_range(0, 1) == 1)
                ? A_CFAIL : A_CBOTH;
      else             a.act = A_OK;
    end
    a.code = code;
    a.ack_dly = $urandom_range(0, 2);
    if (a.dly < 0)      a.dly = $urandom_range(0, T);
    else if (a.dly > T) a.dly = T;
  endtask

  // reference model: phases 2,3,1; each attempt either
  // advances, retries (up to MAXR) or ends the sequence
  task automatic build(input logic [1:0] sl, input int T);
    int   codes[3];
    int   r;
    bit   stop;
    bit   adv;
    att_t a;
    codes = '{2, 3, 1};
    stop = 0; fin_kind = 0; fin_fc = 0;
    for (int p = 0; p < 3; p++) begin
      if (!stop) begin
        r = 0; adv = 0;
        while (!adv && !stop) begin
          next_att(codes[p], T, a);
          plan.push_back(a);
          sbq.push_back(mk_issue(codes[p], r, int'(sl)));
          case (a.act)
            A_OK: adv = 1;
            A_CFAIL, A_CBOTH: begin
              fin_kind = 2; fin_fc = 2; stop = 1;
            end
            A_TMO, A_BUSY: begin
              if (r < MAXR) r++;
              else begin
                fin_kind = 2; stop = 1;
                fin_fc = (a.act == A_TMO) ? 1 : 3;
              end
            end
            default: stop = 1;
          endcase
        end
      end
    end
    if (!stop) fin_kind = 1;
    if (fin_kind != 0)
      sbq.push_back(mk_fin(fin_kind == 1, fin_fc, int'(sl)));
  endtask

  task automatic drive(input att_t a);
    case (a.act)
      A_OK:
        if (a.code == 3) bus.cert_done = 1'b1;
        else             bus.resp_valid = 1'b1;
      A_TMO:
        if (a.code == 3) bus.resp_valid = 1'b1;
        else             bus.cert_done = 1'b1;
      A_BUSY:  bus.busy_err = 1'b1;
      A_CFAIL: bus.cert_fail = 1'b1;
      A_CBOTH: begin
        bus.cert_fail = 1'b1;
        bus.cert_done = 1'b1;
      end
      A_ABORT: bus.abort = 1'b1;
      default: ;
    endcase
  endtask

  task automatic run_att(input att_t a, input int T);
    int n;
    int exp_n;
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.init_req) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("issue_seen", 32'(seen), 1);
    if (!seen) return;
    if (a.act == A_RST) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_init_req", 32'(bus.init_req), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_flags", 32'({bus.auth_done,
            bus.auth_fail, bus.fail_code}), 0);
      check("rst_regs", 32'({bus.req_type,
            bus.slot, bus.retry_cnt}), 0);
      return;
    end
    repeat (a.ack_dly) @(negedge clk);
    bus.init_ack = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      bus.start = 1'b1;
      bus.slot_sel = 2'($urandom);
    end
    @(negedge clk);
    bus.init_ack = 1'b0;
    bus.start = 1'b0;
    check("ack_to_init", 32'(bus.ack_to_init), 1);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!bus.init_req) break;
      n++;
      if (i == 1)
        check("ack_one_cycle", 32'(bus.ack_to_init), 0);
      if (i == a.dly) drive(a);
      @(negedge clk);
      bus.resp_valid = 1'b0;
      bus.cert_done  = 1'b0;
      bus.cert_fail  = 1'b0;
      bus.busy_err   = 1'b0;
      bus.abort      = 1'b0;
    end
    exp_n = (a.act == A_TMO) ? T + 1 : a.dly + 1;
    check("wait_len", n, exp_n);
    if (a.act == A_ABORT)
      check("abort_clean", 32'({bus.busy,
            bus.auth_done, bus.auth_fail}), 0);
  endtask

  task automatic run_seq(input logic [1:0] sl, input int T);
    att_t a;
    build(sl, T);
    bus.timeout_val = T;
    bus.slot_sel = sl;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.slot_sel = 2'($urandom);
    while (plan.size() > 0) begin
      a = plan.pop_front();
      run_att(a, T);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("hold_done", 32'(bus.auth_done), fin_kind == 1);
    check("hold_fail", 32'(bus.auth_fail), fin_kind == 2);
    check("hold_code", 32'(bus.fail_code), fin_fc);
  endtask

  // monitor: pops the scoreboard on each new request and
  // on each completion, and checks the 1-cycle GAP
  initial begin : monitor
    logic prev_req;
    logic prev_fin;
    int   gap;
    exp_t e;
    prev_req = 0; prev_fin = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (bus.init_req && !prev_req) begin
        if (gap > 0) check("gap_len", gap, 1);
        gap = 0;
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_issue: got %0d expected none",
                   bus.req_type);
        end else begin
          e = sbq.pop_front();
          check("kind_issue", 0, 32'(e.fin));
          check("req_type", 32'(bus.req_type), e.rt);
          check("retry_cnt", 32'(bus.retry_cnt), e.rc);
          check("slot", 32'(bus.slot), e.sl);
          check("busy_issue", 32'(bus.busy), 1);
          check("flags_clear", 32'({bus.auth_done,
                bus.auth_fail, bus.fail_code}), 0);
        end
      end
      if (!bus.busy) gap = 0;
      else if (!bus.init_req) gap++;
      if ((bus.auth_done || bus.auth_fail) && !prev_fin) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_final: got done %0d fail %0d expected none",
                   bus.auth_done, bus.auth_fail);
        end else begin
          e = sbq.pop_front();
          check("kind_final", 1, 32'(e.fin));
          check("auth_done", 32'(bus.auth_done), 32'(e.done));
          check("auth_fail", 32'(bus.auth_fail), 32'(!e.done));
          check("fail_code", 32'(bus.fail_code), e.fc);
          check("busy_final", 32'(bus.busy), 0);
          check("req_final", 32'(bus.init_req), 0);
          check("slot_final", 32'(bus.slot), e.sl);
        end
      end
      prev_req = bus.init_req;
      prev_fin = bus.auth_done || bus.auth_fail;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.start = 0; bus.abort = 0; bus.slot_sel = 0;
    bus.init_ack = 0; bus.resp_valid = 0;
    bus.cert_done = 0; bus.cert_fail = 0;
    bus.busy_err = 0; bus.timeout_val = '0;
    repeat (3) @(negedge clk);
    check("reset_req", 32'({bus.init_req,
          bus.req_type}), 0);
    check("reset_slot_retry", 32'({bus.slot,
          bus.retry_cnt}), 0);
    check("reset_flags", 32'({bus.ack_to_init, bus.busy,
          bus.auth_done, bus.auth_fail}), 0);
    check("reset_code", 32'(bus.fail_code), 0);
    reset = 1'b0;
    @(negedge clk);

    fq(A_OK, -1); fq(A_OK, -1); fq(A_OK, -1);
    run_seq(2'd2, 5);

    repeat (4) fq(A_TMO, -1);
    run_seq(2'd1, 10);

    fq(A_OK, -1); fq(A_CBOTH, -1);
    run_seq(2'd3, 6);

    fq(A_OK, -1); fq(A_OK, -1);
    fq(A_BUSY, -1); fq(A_OK, -1);
    run_seq(2'd0, 4);

    fq(A_OK, 99); fq(A_OK, 99); fq(A_OK, 99);
    run_seq(2'd1, 3);

    repeat (4) fq(A_BUSY, -1);
    run_seq(2'd2, 7);

    fq(A_OK, -1); fq(A_ABORT, 2);
    run_seq(2'd3, 5);

    fq(A_OK, -1); fq(A_RST, 0);
    run_seq(2'd1, 5);

    run_seq(2'd2, 0);

    for (int k = 0; k < 30; k++)
      run_seq(2'($urandom), $urandom_range(0, 8));

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
